// File: rtl/simd_cast_pipe.sv
// Multi-lane, two-stage fixed-point cast unit: rescale/round in stage 1, saturate/extend in stage 2.
// Valid/ready flow control with a shared stall enable; saturating count of saturated lanes delivered.
module simd_cast_pipe #(
  parameter int NUM_LANES     = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FUNCTION_BITS-1:0]       fn,
  input  logic [7:0]                     src1_integer_bits,
  input  logic [7:0]                     dest_integer_bits,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*BIT_WIDTH-1:0] data_out,
  output logic [NUM_LANES-1:0]           out_sat,
  input  logic                           clear_sat,
  output logic [15:0]                    sat_count
);

  localparam int WW = 2*BIT_WIDTH + 2;
  localparam int QW = $clog2(BIT_WIDTH + 1) + 2;

  typedef enum logic [2:0] {M_ZERO, M_S16, M_U8, M_S4, M_SW, M_FLOOR, M_CEIL} mode_t;
  typedef enum logic [1:0] {R_FLOOR, R_HALF_UP, R_HALF_EVEN} rnd_t;
  typedef struct packed {
    logic                 sat;
    logic [BIT_WIDTH-1:0] val;
  } lane_res_t;

  function automatic logic [WW-1:0] low_mask(input int n);
    return (WW'(1) << n) - WW'(1);
  endfunction

  function automatic logic signed [WW-1:0] stage1_lane(
    input logic [BIT_WIDTH-1:0] x,
    input mode_t                m,
    input rnd_t                 rm,
    input int                   sh,
    input int                   fi
  );
    logic signed [WW-1:0] w;
    logic signed [WW-1:0] q;
    logic [WW-1:0]        rem;
    logic [WW-1:0]        half;
    w    = {{(WW-BIT_WIDTH){x[BIT_WIDTH-1]}}, x};
    q    = w;
    rem  = '0;
    half = '0;
    case (m)
      M_ZERO:  q = '0;
      M_FLOOR: q = w & ~low_mask(fi);
      M_CEIL:  q = (w + low_mask(fi)) & ~low_mask(fi);
      default: begin
        if (sh > 0) begin
          rem  = w & low_mask(sh);
          half = WW'(1) << (sh - 1);
          if (rm == R_HALF_UP) begin
            q = (w + $signed(half)) >>> sh;
          end else begin
            q = w >>> sh;
            // ties go to the even quotient; the floor quotient's LSB decides
            if (rm == R_HALF_EVEN && (rem > half || (rem == half && q[0])))
              q = q + 1;
          end
        end else begin
          q = w <<< (-sh);
        end
      end
    endcase
    return q;
  endfunction

  function automatic lane_res_t stage2_lane(
    input logic signed [WW-1:0] v,
    input mode_t                m,
    input int                   wout,
    input int                   fi
  );
    logic signed [WW-1:0] hi;
    logic signed [WW-1:0] lo;
    logic signed [WW-1:0] r;
    lane_res_t            o;
    hi    = $signed((WW'(1) << (wout - 1)) - WW'(1));
    lo    = ~hi;
    r     = v;
    o.sat = 1'b0;
    if (m == M_U8) begin
      hi = WW'(255);
      lo = '0;
    end
    // ceil clamps to the largest representable multiple of 2^fi
    if (m == M_CEIL)
      hi = $signed((WW'(1) << (BIT_WIDTH - 1)) - WW'(1)) & ~low_mask(fi);
    if (m == M_ZERO) begin
      r = '0;
    end else if (m != M_FLOOR) begin
      if (r > hi) begin
        r     = hi;
        o.sat = 1'b1;
      end else if (r < lo) begin
        r     = lo;
        o.sat = 1'b1;
      end
    end
    o.val = r[BIT_WIDTH-1:0];
    return o;
  endfunction

  mode_t                 mode_c;
  rnd_t                  rnd_c;
  logic [QW-1:0]         wout_c;
  logic [QW-1:0]         fi_c;
  logic [QW-1:0]         fo_c;
  logic signed [QW+1:0]  sh_c;
  logic                  en;

  logic                  s1_valid;
  mode_t                 s1_mode;
  logic [QW-1:0]         s1_wout;
  logic [QW-1:0]         s1_fi;
  logic signed [WW-1:0]  s1_val  [NUM_LANES];
  logic signed [WW-1:0]  s1_next [NUM_LANES];

  lane_res_t                    s2_res [NUM_LANES];
  logic [NUM_LANES*BIT_WIDTH-1:0] s2_data;
  logic [NUM_LANES-1:0]         s2_sat;
  logic [16:0]                  sat_pop;
  logic [16:0]                  sat_sum;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    mode_c = M_ZERO;
    rnd_c  = R_FLOOR;
    wout_c = QW'(BIT_WIDTH);
    case (fn)
      FUNCTION_BITS'(4'b0000): begin mode_c = M_S16; wout_c = QW'(16); end
      FUNCTION_BITS'(4'b0001): begin mode_c = M_U8;  wout_c = QW'(8); rnd_c = R_HALF_UP; end
      FUNCTION_BITS'(4'b0010): begin mode_c = M_S4;  wout_c = QW'(4); end
      FUNCTION_BITS'(4'b0011): mode_c = M_SW;
      FUNCTION_BITS'(4'b1100): begin mode_c = M_SW;  rnd_c = R_HALF_EVEN; end
      FUNCTION_BITS'(4'b1000): mode_c = M_FLOOR;
      FUNCTION_BITS'(4'b1001): mode_c = M_CEIL;
      default: ;
    endcase
    fi_c = (int'(src1_integer_bits) >= BIT_WIDTH) ? '0
         : QW'(BIT_WIDTH - int'(src1_integer_bits));
    if (mode_c == M_U8 || int'(dest_integer_bits) >= int'(wout_c))
      fo_c = '0;
    else
      fo_c = QW'(int'(wout_c) - int'(dest_integer_bits));
    sh_c = $signed({2'b00, fi_c}) - $signed({2'b00, fo_c});
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++)
      s1_next[k] = stage1_lane(data_in[k*BIT_WIDTH +: BIT_WIDTH], mode_c, rnd_c,
                               int'(sh_c), int'(fi_c));
  end

  always_comb begin
    s2_data = '0;
    s2_sat  = '0;
    sat_pop = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      s2_res[k]                         = stage2_lane(s1_val[k], s1_mode, int'(s1_wout), int'(s1_fi));
      s2_data[k*BIT_WIDTH +: BIT_WIDTH] = s2_res[k].val;
      s2_sat[k]                         = s2_res[k].sat;
      sat_pop                           = sat_pop + 17'(out_sat[k]);
    end
    sat_sum = {1'b0, sat_count} + sat_pop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_mode   <= M_ZERO;
      s1_wout   <= '0;
      s1_fi     <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++)
        s1_val[k] <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= '0;
      sat_count <= '0;
    end else begin
      if (en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= mode_c;
          s1_wout <= wout_c;
          s1_fi   <= fi_c;
          for (int unsigned k = 0; k < NUM_LANES; k++)
            s1_val[k] <= s1_next[k];
        end
        out_valid <= s1_valid;
        if (s1_valid) begin
          data_out <= s2_data;
          out_sat  <= s2_sat;
        end
      end
      if (clear_sat)
        sat_count <= '0;
      else if (out_valid && out_ready)
        sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule
